parity_error_monitor: RTL and testbench



---
 rtl/parity_error_monitor_pkg.sv | 14 +
 rtl/parity_error_monitor_error_fifo.sv | 52 +++++
 rtl/parity_error_monitor.sv | 83 ++++++++
 tb/tb_parity_error_monitor.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_error_monitor_pkg.sv
// Shared sizes and the error-entry record for the parity error monitor.
package parity_error_monitor_pkg;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_W      = 8;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } err_entry_t;

endpackage

// File: rtl/parity_error_monitor_error_fifo.sv
// Small synchronous FIFO holding failing words until the host pops them.
module parity_error_monitor_error_fifo
  import parity_error_monitor_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int W     = $bits(err_entry_t)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/parity_error_monitor.sv
// Re-checks fetched word parity, queues failures and keeps error statistics.
module parity_error_monitor
  import parity_error_monitor_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  input  logic              pop,
  output logic              match,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic              fifo_full,
  output logic              overflow,
  output logic [CNT_W-1:0]  err_count,
  output logic              sweep_done,
  output logic [ADDR_W:0]   sweep_errors
);

  localparam int EW = ADDR_W + DATA_W;

  logic            ok;
  logic            err;
  logic            sweep_end;
  logic            fifo_empty;
  logic [EW-1:0]   head;
  logic [ADDR_W:0] sweep_cnt;

  assign ok        = (^in_data) == in_parity;
  assign err       = in_valid && !ok;
  assign sweep_end = in_valid && (in_addr == {ADDR_W{1'b1}});

  parity_error_monitor_error_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (err),
    .pop   (pop),
    .wdata ({in_addr, in_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign err_valid = !fifo_empty;
  assign err_addr  = head[EW-1:DATA_W];
  assign err_data  = head[DATA_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      match        <= 1'b1;
      overflow     <= 1'b0;
      err_count    <= '0;
      sweep_done   <= 1'b0;
      sweep_errors <= '0;
      sweep_cnt    <= '0;
    end else begin
      sweep_done <= sweep_end;
      if (in_valid) match <= ok;
      // Full with no pop draining the head means this error is lost.
      if (err && fifo_full && !pop) overflow <= 1'b1;
      if (err && err_count != {CNT_W{1'b1}})
        err_count <= err_count + CNT_W'(1);
      if (sweep_end) begin
        sweep_errors <= sweep_cnt + (ADDR_W+1)'(err);
        sweep_cnt    <= '0;
      end else if (err) begin
        sweep_cnt <= sweep_cnt + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_error_monitor.sv
// Directed self-checking bench for parity_error_monitor.
module tb_parity_error_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_addr = '0;
  logic [7:0] in_data = '0;
  logic       in_parity = 1'b0;
  logic       pop = 1'b0;
  logic       match;
  logic       err_valid;
  logic [3:0] err_addr;
  logic [7:0] err_data;
  logic       fifo_full;
  logic       overflow;
  logic [7:0] err_count;
  logic       sweep_done;
  logic [4:0] sweep_errors;

  int errors = 0;
  int checks = 0;

  parity_error_monitor dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_parity    (in_parity),
    .pop          (pop),
    .match        (match),
    .err_valid    (err_valid),
    .err_addr     (err_addr),
    .err_data     (err_data),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .err_count    (err_count),
    .sweep_done   (sweep_done),
    .sweep_errors (sweep_errors)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    pop      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // 0x01 with parity 0 is always bad; 0x1F with parity 1 is always good.
  task automatic drive(input logic [3:0] a, input logic bad, input logic p);
    in_valid  = 1'b1;
    in_addr   = a;
    in_data   = bad ? 8'h01 : 8'h1F;
    in_parity = bad ? 1'b0 : 1'b1;
    pop       = p;
    step();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (match !== 1'b1 || err_valid !== 1'b0 || err_addr !== 4'd0 ||
        err_data !== 8'd0 || fifo_full !== 1'b0 || overflow !== 1'b0 ||
        err_count !== 8'd0 || sweep_done !== 1'b0 || sweep_errors !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: match=%b ev=%b ea=%0d ed=%h full=%b ovf=%b cnt=%0d sd=%b se=%0d",
               match, err_valid, err_addr, err_data, fifo_full, overflow,
               err_count, sweep_done, sweep_errors);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_sweep();
    int bad_match = 0;
    int early_done = 0;
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b0, 1'b0);
      if (match !== 1'b1) bad_match++;
      if (i < 15 && sweep_done !== 1'b0) early_done++;
    end
    checks++;
    if (bad_match != 0) begin
      errors++;
      $display("FAIL clean_match: bad cycles got %0d expected 0", bad_match);
    end
    checks++;
    if (sweep_done !== 1'b1 || early_done != 0) begin
      errors++;
      $display("FAIL clean_sweep_done: got %b early=%0d expected 1 early=0",
               sweep_done, early_done);
    end
    checks++;
    if (sweep_errors !== 5'd0 || err_count !== 8'd0 || err_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_stats: se=%0d cnt=%0d ev=%b expected 0 0 0",
               sweep_errors, err_count, err_valid);
    end
    idle();
    step();
    checks++;
    if (sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL sweep_done_pulse: got %b expected 0", sweep_done);
    end
  endtask

  task automatic test_single_error();
    do_reset();
    in_valid  = 1'b1;
    in_addr   = 4'd5;
    in_data   = 8'h52;
    in_parity = 1'b0;
    step();
    checks++;
    if (match !== 1'b0 || err_valid !== 1'b1 || err_addr !== 4'd5 ||
        err_data !== 8'h52 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL single_error: match=%b ev=%b ea=%0d ed=%h cnt=%0d expected 0 1 5 52 1",
               match, err_valid, err_addr, err_data, err_count);
    end
    in_valid = 1'b0;
    pop      = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (err_valid !== 1'b0 || match !== 1'b0 || err_addr !== 4'd0) begin
      errors++;
      $display("FAIL single_pop: ev=%b match=%b ea=%0d expected 0 0 0",
               err_valid, match, err_addr);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'(i), 1'b1, 1'b0);
      if (i == 3) begin
        checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL full_after_4: full=%b ovf=%b expected 1 0", fifo_full, overflow);
        end
      end
    end
    idle();
    checks++;
    if (overflow !== 1'b1 || err_count !== 8'd5 || err_addr !== 4'd0) begin
      errors++;
      $display("FAIL overflow: ovf=%b cnt=%0d head=%0d expected 1 5 0",
               overflow, err_count, err_addr);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (err_valid !== 1'b1 || err_addr !== 4'(k)) begin
        errors++;
        $display("FAIL drain_ovf[%0d]: ev=%b addr=%0d expected 1 %0d",
                 k, err_valid, err_addr, k);
      end
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    checks++;
    if (err_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_ovf_end: ev=%b ovf=%b expected 0 1", err_valid, overflow);
    end
  endtask

  task automatic test_push_pop();
    logic [3:0] exp_order [4];
    exp_order = '{4'd2, 4'd3, 4'd4, 4'd9};
    do_reset();
    for (int i = 1; i <= 4; i++) drive(4'(i), 1'b1, 1'b0);
    drive(4'd9, 1'b1, 1'b1);
    idle();
    checks++;
    if (overflow !== 1'b0 || fifo_full !== 1'b1 || err_addr !== 4'd2) begin
      errors++;
      $display("FAIL full_push_pop: ovf=%b full=%b head=%0d expected 0 1 2",
               overflow, fifo_full, err_addr);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (err_valid !== 1'b1 || err_addr !== exp_order[k]) begin
        errors++;
        $display("FAIL drain_pp[%0d]: ev=%b addr=%0d expected 1 %0d",
                 k, err_valid, err_addr, exp_order[k]);
      end
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    drive(4'd7, 1'b1, 1'b1);
    idle();
    checks++;
    if (err_valid !== 1'b1 || err_addr !== 4'd7 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL empty_push_pop: ev=%b addr=%0d full=%b expected 1 7 0",
               err_valid, err_addr, fifo_full);
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (err_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_push_pop_count: ev=%b expected 0 (one entry only)", err_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) drive(4'(i % 16), 1'b1, 1'b0);
    idle();
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate: cnt=%0d expected 255", err_count);
    end
    drive(4'd3, 1'b1, 1'b0);
    idle();
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate_hold: cnt=%0d expected 255", err_count);
    end
  endtask

  task automatic test_sweep_count();
    do_reset();
    for (int i = 0; i < 16; i++) drive(4'(i), 1'b1, 1'b1);
    checks++;
    if (sweep_done !== 1'b1 || sweep_errors !== 5'd16) begin
      errors++;
      $display("FAIL bad_sweep: sd=%b se=%0d expected 1 16", sweep_done, sweep_errors);
    end
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b0, 1'b1);
      if (i == 7) begin
        checks++;
        if (sweep_errors !== 5'd16 || sweep_done !== 1'b0) begin
          errors++;
          $display("FAIL sweep_hold: se=%0d sd=%b expected 16 0", sweep_errors, sweep_done);
        end
      end
    end
    idle();
    checks++;
    if (sweep_done !== 1'b1 || sweep_errors !== 5'd0) begin
      errors++;
      $display("FAIL clean_after_bad: sd=%b se=%0d expected 1 0", sweep_done, sweep_errors);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    for (int i = 0; i < 3; i++) drive(4'(i + 2), 1'b1, 1'b0);
    idle();
    checks++;
    if (err_count !== 8'd3 || err_valid !== 1'b1 || match !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: cnt=%0d ev=%b match=%b expected 3 1 0",
               err_count, err_valid, match);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (match !== 1'b1 || err_valid !== 1'b0 || err_addr !== 4'd0 ||
        err_data !== 8'd0 || fifo_full !== 1'b0 || overflow !== 1'b0 ||
        err_count !== 8'd0 || sweep_done !== 1'b0 || sweep_errors !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: match=%b ev=%b ea=%0d ed=%h full=%b ovf=%b cnt=%0d sd=%b se=%0d",
               match, err_valid, err_addr, err_data, fifo_full, overflow,
               err_count, sweep_done, sweep_errors);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (err_valid !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL post_reset: ev=%b cnt=%0d expected 0 0", err_valid, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_single_error();
    test_overflow();
    test_push_pop();
    test_saturation();
    test_sweep_count();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
